// File: rtl/gbprocessor_q_if.sv
// gbprocessor_q_if: beat channel into the queued processor (opcode + immediate, valid/ready).
// The master offers beats; the slave accepts on a rising edge with valid and ready both high.
interface gbprocessor_q_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        instruction;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output instruction,
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  instruction,
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/gbprocessor_q.sv
// gbprocessor_q: queued Game Boy-style datapath with probe bus and sticky HALT.
// Optional feature macro GBPROC_Q_BYPASS_EN: an empty, running queue executes the accepted beat on the same edge.

// gbprocessor_q_fifo: generic synchronous FIFO with occupancy counter.
// Latency: head visible the clock after push; pop_dat is combinational from the read pointer.
// Backpressure: full asserts at DEPTH entries; caller must not push when full or pop when empty.
module gbprocessor_q_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop_rdy)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_vld, pop_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
endmodule

// gbprocessor_q: 8-register datapath fed from an instruction queue, one instruction per clock.
// Latency: 1 clock accept-to-execute (0 when GBPROC_Q_BYPASS_EN and queue empty and running).
// Backpressure: ready = queue not full; HALT stops draining so the queue fills and ready falls.
module gbprocessor_q #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    gbprocessor_q_if.slave        host,
    output logic                  halted,
    output logic [8*DATA_W-1:0]   probe
);
    localparam int ZB = DATA_W - 1;
    localparam int NB = DATA_W - 2;
    localparam int HB = DATA_W - 3;
    localparam int CB = DATA_W - 4;

    typedef struct packed {
        logic [7:0]        op;
        logic [DATA_W-1:0] imm;
    } beat_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_nxt;

    beat_t in_beat;
    beat_t head_beat;
    beat_t ex_beat;
    logic  q_empty;
    logic  q_full;
    logic  in_fire;
    logic  bypass;
    logic  push;
    logic  pop;
    logic  ex_vld;

    logic [DATA_W-1:0] rf [8];
    logic [DATA_W-1:0] f_q;

    logic [7:0]        ex_op;
    logic [DATA_W-1:0] ex_imm;
    logic [2:0]        ex_dst;
    logic [2:0]        ex_src;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] dst_val;

    logic              cin;
    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic              alu_n;
    logic              alu_h;
    logic              alu_c;

    logic              rf_we;
    logic [2:0]        rf_widx;
    logic [DATA_W-1:0] rf_wdat;
    logic              f_we;
    logic [DATA_W-1:0] f_nxt;
    logic              halt_req;

    assign in_beat.op  = host.instruction;
    assign in_beat.imm = host.data;
    assign host.ready  = ~q_full;
    assign in_fire     = host.valid & ~q_full;

`ifdef GBPROC_Q_BYPASS_EN
    assign bypass = in_fire & q_empty & ~halted;
`else
    assign bypass = 1'b0;
`endif

    assign push    = in_fire & ~bypass;
    assign pop     = ~q_empty & ~halted;
    assign ex_vld  = pop | bypass;
    assign ex_beat = bypass ? in_beat : head_beat;

    gbprocessor_q_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clock    (clock),
        .reset    (reset),
        .push_vld (push),
        .push_dat (in_beat),
        .pop_rdy  (pop),
        .pop_dat  (head_beat),
        .empty    (q_empty),
        .full     (q_full)
    );

    // Register index 6 names no register: reads see zero, writes are dropped.
    assign ex_op   = ex_beat.op;
    assign ex_imm  = ex_beat.imm;
    assign ex_dst  = ex_op[5:3];
    assign ex_src  = ex_op[2:0];
    assign acc     = rf[7];
    assign src_val = (ex_src == 3'd6) ? '0 : rf[ex_src];
    assign dst_val = (ex_dst == 3'd6) ? '0 : rf[ex_dst];

    // Carry/borrow out of bit 3 is recovered as the carry into bit 4.
    always_comb begin
        cin     = 1'b0;
        wide    = '0;
        alu_res = '0;
        alu_n   = 1'b0;
        alu_h   = 1'b0;
        alu_c   = 1'b0;
        case (ex_op[5:3])
            3'd0, 3'd1: begin
                cin     = ex_op[3] & f_q[CB];
                wide    = {1'b0, acc} + {1'b0, src_val} + {{DATA_W{1'b0}}, cin};
                alu_res = wide[DATA_W-1:0];
                alu_h   = acc[4] ^ src_val[4] ^ wide[4];
                alu_c   = wide[DATA_W];
            end
            3'd2, 3'd3, 3'd7: begin
                cin     = (ex_op[5:3] == 3'd3) & f_q[CB];
                wide    = {1'b0, acc} - {1'b0, src_val} - {{DATA_W{1'b0}}, cin};
                alu_res = wide[DATA_W-1:0];
                alu_n   = 1'b1;
                alu_h   = acc[4] ^ src_val[4] ^ wide[4];
                alu_c   = wide[DATA_W];
            end
            3'd4: begin
                alu_res = acc & src_val;
                alu_h   = 1'b1;
            end
            3'd5:    alu_res = acc ^ src_val;
            default: alu_res = acc | src_val;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_widx  = ex_dst;
        rf_wdat  = '0;
        f_we     = 1'b0;
        f_nxt    = '0;
        halt_req = 1'b0;
        if (ex_vld) begin
            case (ex_op[7:6])
                2'b00: begin
                    if (ex_dst != 3'd6) begin
                        if (ex_src == 3'b110) begin
                            rf_we   = 1'b1;
                            rf_wdat = ex_imm;
                        end else if (ex_src[2:1] == 2'b10) begin
                            rf_we     = 1'b1;
                            f_we      = 1'b1;
                            rf_wdat   = ex_op[0] ? dst_val - 1'b1 : dst_val + 1'b1;
                            f_nxt[ZB] = (rf_wdat == '0);
                            f_nxt[NB] = ex_op[0];
                            f_nxt[HB] = ex_op[0] ? (dst_val[3:0] == 4'h0) : (dst_val[3:0] == 4'hF);
                            f_nxt[CB] = f_q[CB];
                        end
                    end
                end
                2'b01: begin
                    if (ex_op == 8'h76) begin
                        halt_req = 1'b1;
                    end else begin
                        rf_we   = (ex_dst != 3'd6);
                        rf_wdat = src_val;
                    end
                end
                2'b10: begin
                    rf_we     = (ex_op[5:3] != 3'd7);
                    rf_widx   = 3'd7;
                    rf_wdat   = alu_res;
                    f_we      = 1'b1;
                    f_nxt[ZB] = (alu_res == '0);
                    f_nxt[NB] = alu_n;
                    f_nxt[HB] = alu_h;
                    f_nxt[CB] = alu_c;
                end
                default: begin
                    rf_we = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                rf[i] <= (i < 6) ? DATA_W'(i + 1) : '0;
            end
            f_q <= '0;
        end else begin
            if (rf_we) rf[rf_widx] <= rf_wdat;
            if (f_we)  f_q <= f_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        if (state_q == ST_RUN && halt_req) state_nxt = ST_HALT;
    end

    assign halted = (state_q == ST_HALT);
    assign probe  = {rf[7], rf[0], rf[1], rf[2], rf[3], f_q, rf[4], rf[5]};
endmodule

// File: tb/tb_gbprocessor_q.sv
// tb_gbprocessor_q: directed vectors with hand-computed register/flag values for gbprocessor_q.
module tb_gbprocessor_q;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam logic [63:0] RST_PROBE = 64'h0001020304000506;
    localparam int RA = 0, RB = 1, RC = 2, RD = 3, RE = 4, RF = 5, RH = 6, RL = 7;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        halted;
    logic [63:0] probe;
    int          errors = 0;
    int          checks = 0;

    gbprocessor_q_if #(.DATA_W(DATA_W)) bus();

    gbprocessor_q #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .host   (bus),
        .halted (halted),
        .probe  (probe)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] reg_of(input int idx);
        return probe[63-8*idx -: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance with valid still high.
    task automatic send(input logic [7:0] op, input logic [7:0] d);
        int waited = 0;
        bus.valid       = 1'b1;
        bus.instruction = op;
        bus.data        = d;
        while (!bus.ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        chk("send_rdy", bus.ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic flush();
        bus.valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset();
        bus.valid = 1'b0;
        reset     = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid       = 1'b0;
        bus.instruction = 8'h00;
        bus.data        = 8'h00;

        // reset state, then LD B,imm / LD A,B with first-result latency
        do_reset();
        chk("rst_probe", probe, RST_PROBE);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_halted", halted, 1'b0);
        send(8'h06, 8'h3C);
        bus.valid = 1'b0;
`ifdef GBPROC_Q_BYPASS_EN
        chk("lat_b", reg_of(RB), 8'h3C);
`else
        chk("lat_b", reg_of(RB), 8'h01);
`endif
        @(negedge clock);
        chk("ld_b", reg_of(RB), 8'h3C);
        send(8'h78, 8'h00);
        flush();
        chk("ld_a_a", reg_of(RA), 8'h3C);
        chk("ld_a_b", reg_of(RB), 8'h3C);
        chk("ld_a_f", reg_of(RF), 8'h00);

        // ADD/ADC carry chain and INC wrap with C preserved
        do_reset();
        send(8'h3E, 8'hFF);
        send(8'h81, 8'h00);
        flush();
        chk("add_a", reg_of(RA), 8'h01);
        chk("add_f", reg_of(RF), 8'h30);
        send(8'h89, 8'h00);
        flush();
        chk("adc_a", reg_of(RA), 8'h04);
        chk("adc_f", reg_of(RF), 8'h00);
        send(8'h3E, 8'hFC);
        send(8'h87, 8'h00);
        flush();
        chk("add_aa_a", reg_of(RA), 8'hF8);
        chk("add_aa_f", reg_of(RF), 8'h30);
        send(8'h3E, 8'hFF);
        send(8'h3C, 8'h00);
        flush();
        chk("inc_wrap_a", reg_of(RA), 8'h00);
        chk("inc_wrap_f", reg_of(RF), 8'hB0);

        // CP, DEC, SUB, logic ops, SBC, index-6 forms and undefined opcodes
        do_reset();
        send(8'h3E, 8'h10);
        send(8'h06, 8'h10);
        send(8'hB8, 8'h00);
        flush();
        chk("cp_a", reg_of(RA), 8'h10);
        chk("cp_f", reg_of(RF), 8'hC0);
        send(8'h05, 8'h00);
        flush();
        chk("dec_b", reg_of(RB), 8'h0F);
        chk("dec_f", reg_of(RF), 8'h60);
        send(8'h91, 8'h00);
        flush();
        chk("sub_a", reg_of(RA), 8'h0E);
        chk("sub_f", reg_of(RF), 8'h60);
        send(8'hA0, 8'h00);
        flush();
        chk("and_a", reg_of(RA), 8'h0E);
        chk("and_f", reg_of(RF), 8'h20);
        send(8'hAF, 8'h00);
        flush();
        chk("xor_a", reg_of(RA), 8'h00);
        chk("xor_f", reg_of(RF), 8'h80);
        send(8'h91, 8'h00);
        flush();
        chk("sub_borrow_a", reg_of(RA), 8'hFE);
        chk("sub_borrow_f", reg_of(RF), 8'h70);
        send(8'h98, 8'h00);
        flush();
        chk("sbc_a", reg_of(RA), 8'hEE);
        chk("sbc_f", reg_of(RF), 8'h60);
        send(8'hB5, 8'h00);
        send(8'h56, 8'h00);
        send(8'h77, 8'h00);
        flush();
        chk("or_ld6_probe", probe, 64'hEE0F020004000506);
        send(8'hC3, 8'h00);
        send(8'h36, 8'h99);
        send(8'h34, 8'h00);
        flush();
        chk("nop_probe", probe, 64'hEE0F020004000506);

        // HALT freezes registers; queue fills to DEPTH and the fifth beat is held
        do_reset();
        send(8'h3E, 8'h55);
        send(8'h76, 8'h00);
        for (int i = 0; i < DEPTH; i++) send(8'h3C, 8'h00);
        chk("halt_flag", halted, 1'b1);
        chk("halt_full_rdy", bus.ready, 1'b0);
        bus.instruction = 8'h3D;
        repeat (3) @(negedge clock);
        chk("halt_held_rdy", bus.ready, 1'b0);
        chk("halt_frozen", probe, 64'h5501020304000506);
        bus.valid = 1'b0;

        // back-to-back INC A stream
        do_reset();
        bus.valid       = 1'b1;
        bus.instruction = 8'h3C;
        bus.data        = 8'h00;
        for (int i = 0; i < 10; i++) begin
            chk("stream_rdy", bus.ready, 1'b1);
            @(posedge clock);
            @(negedge clock);
        end
        flush();
        chk("stream_a", reg_of(RA), 8'h0A);
        chk("stream_f", reg_of(RF), 8'h00);

        // asynchronous reset with three beats queued behind HALT
        do_reset();
        send(8'h3E, 8'hAA);
        send(8'h76, 8'h00);
        for (int i = 0; i < 3; i++) send(8'h3C, 8'h00);
        bus.valid = 1'b0;
        @(negedge clock);
        chk("q3_rdy", bus.ready, 1'b1);
        chk("q3_halted", halted, 1'b1);
        chk("q3_a", reg_of(RA), 8'hAA);
        #2 reset = 1'b0;
        #1;
        chk("arst_probe", probe, RST_PROBE);
        chk("arst_rdy", bus.ready, 1'b1);
        chk("arst_halted", halted, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("no_replay_probe", probe, RST_PROBE);
        chk("no_replay_halted", halted, 1'b0);
        chk("no_replay_h", reg_of(RH), 8'h05);
        chk("no_replay_l", reg_of(RL), 8'h06);
        chk("no_replay_c", reg_of(RC), 8'h02);
        chk("no_replay_d", reg_of(RD), 8'h03);
        chk("no_replay_e", reg_of(RE), 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gbprocessor_q.md
# gbprocessor_q

Parametrised successor of the Game Boy–style datapath. Accepts instruction/data beats through a valid/ready handshake into an instruction queue, executes one queued instruction per clock, and exposes all eight registers on a probe bus. It generalises register width and queue depth, and adds INC/DEC, full carry-chain ALU flags and a sticky HALT state.

## Interface
- `DATA_W`, 8: register, data and ALU width; must be ≥ 5.
- `FIFO_DEPTH`, 4: instruction queue entries; power of two, ≥ 2.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 resets immediately, release is synchronous to `clock`.
- `instruction`  in  8  opcode of the offered beat.
- `data`  in  DATA_W  immediate operand of the offered beat.
- `valid`  in  1  beat offered.
- `ready`  out  1  queue can accept; a beat transfers on a rising edge with `valid`=1 and `ready`=1.
- `halted`  out  1  HALT has executed.
- `probe`  out  8*DATA_W  {A,B,C,D,E,F,H,L}, A in the MSBs.

## Operation
- Register index r = opcode bits: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 none (source reads 0, destination means no write), 7 A.
- F holds flags Z,N,H,C in bits [DATA_W-1:DATA_W-4]; other F bits always 0.
- Decode:
  - 0x00: NOP.
  - 00rrr110, r≠6: LD r,data.
  - 00rrr100 / 00rrr101, r≠6: INC r / DEC r. Z from result; N=0 for INC, 1 for DEC; H = carry/borrow across bit 3; C unchanged.
  - 01dddsss except 0x76: LD d,s. d=6 performs no write; s=6 loads 0.
  - 0x76: HALT. Sets `halted`; execution stops until reset. Queue keeps accepting beats until full.
  - 10ooosss: A ← A op src; F updated. Ops 0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP. CP updates F only.
  - Any other opcode: NOP, no F change.
- ALU arithmetic is modulo 2^DATA_W.
  - C = carry (or borrow) out of bit DATA_W-1; H = carry (or borrow) out of bit 3.
  - ADC/SBC use the current C flag as carry-in.
  - N=1 for SUB, SBC and CP.
  - AND: H=1, C=0. XOR/OR: H=0, C=0.
  - Z=1 iff the result is 0. For CP, the result is A−src.
- Reset values: A=0, B=1, C=2, D=3, E=4, F=0, H=5, L=6, zero-extended to DATA_W; queue empty; `halted`=0; `ready`=1.

## Timing
- `ready` = (occupancy < FIFO_DEPTH), registered from the occupancy counter; no combinational path from `valid`.
- Beat accepted at edge k executes at edge k+1 when the queue was empty and not halted; `probe` shows the result after edge k+1.
- Execution pops the head every cycle while the queue is non-empty and `halted`=0. Sustained throughput is one beat per clock.
- Simultaneous accept and pop: occupancy unchanged; the accepted beat is ordered after all earlier beats.
- Full: `ready`=0. `valid` with `ready`=0 is ignored; the source must hold the beat.
- HALT executes at edge m: `halted`=1 after edge m. Later beats stay queued; occupancy only grows; `ready` falls when the queue reaches FIFO_DEPTH.
- Read/write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- `reset` low mid-stream: queued beats are discarded and all state returns to reset values without waiting for a clock edge.

## Configuration
- `GBPROC_Q_BYPASS_EN` defined: a beat accepted at edge k while the queue is empty and `halted`=0 executes at edge k. It is not stored and the latency is 0. Otherwise, behaviour is as above.
- Not defined: every beat passes through the queue with latency 1.
- The queue, flags and HALT are identical in both builds.

## Test plan
- Reset, then LD B,0x3C (0x06) followed by LD A,B (0x78) → probe A=0x3C, B=0x3C, F=0x00; the first result appears one edge after acceptance (zero edges with bypass).
- A=0xFF, ADD A,C with C=0x02 (0x81) → A=0x01, F=0x30 (H=1, C=1); then ADC A,C (0x89) → A=0x04, F=0x00.
- A=0x10, CP B with B=0x10 (0xB8) → A unchanged, F=0xC0; then DEC B (0x05) → B=0x0F, F=0x60 (N=1, H=1).
- HALT (0x76), then 5 more beats with DEPTH=4 → `halted`=1, registers frozen, `ready`=0 after 4 queued, 5th beat held.
- Back-to-back stream of 10 INC A beats (0x3C) with `valid` held high → A=0x0A after 10 execute edges; `ready` never drops.
- `reset` pulsed low mid-stream with 3 beats queued → `probe`=0x0001020304000506, `ready`=1 and `halted`=0 immediately; queued beats are never executed.
